// File: rtl/axis_golden_compare_ctrl.sv
// Golden-stream comparison run controller: joins DUT and golden AXI-streams,
// counts samples/mismatches, runs a stall watchdog. Optional: GOLD_CMP_BACKPRESSURE_EN.
module axis_golden_compare_ctrl #(
  parameter int DATA_WIDTH     = 10,
  parameter int SAMPLE_COUNT   = 1024,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int MAX_ERRORS     = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dut_valid,
  input  logic [DATA_WIDTH-1:0] dut_data,
  output logic                  dut_ready,
  input  logic                  gold_valid,
  input  logic [DATA_WIDTH-1:0] gold_data,
  output logic                  gold_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  sample_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic [CNT_WIDTH-1:0]  first_err_index,
  output logic                  first_err_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] SAMPLE_TARGET = CNT_WIDTH'(SAMPLE_COUNT);
  localparam logic [CNT_WIDTH-1:0] ERROR_LIMIT   = CNT_WIDTH'(MAX_ERRORS);
  localparam logic [CNT_WIDTH-1:0] WD_LIMIT      = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE       = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX       = '1;
  localparam bit                   ZERO_RUN      = (SAMPLE_COUNT == 0);
  localparam bit                   ABORT_EN      = (MAX_ERRORS != 0);

  state_t               state;
  state_t               state_next;
  logic                 in_run;
  logic                 accept_en;
  logic                 xfer;
  logic                 mismatch;
  logic                 run_start;
  logic                 finish;
  logic                 wd_expire;
  logic                 hit_count;
  logic                 hit_errors;
  logic [CNT_WIDTH-1:0] watchdog;
  logic [CNT_WIDTH-1:0] sample_inc;
  logic [CNT_WIDTH-1:0] mismatch_inc;
  logic [CNT_WIDTH-1:0] sample_after;
  logic [CNT_WIDTH-1:0] mismatch_after;

  assign in_run = (state == RUN);
  assign busy   = in_run;
  assign done   = (state == DONE);

`ifdef GOLD_CMP_BACKPRESSURE_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] lfsr;

  // Reseeded on every run start so each run sees the same stall pattern.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= LFSR_SEED;
    end else if (run_start) begin
      lfsr <= LFSR_SEED;
    end else if (in_run) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign accept_en = lfsr[0];
`else
  assign accept_en = 1'b1;
`endif

  // Each ready depends only on the other stream's valid, so both advance together.
  assign dut_ready  = in_run && !ZERO_RUN && accept_en && gold_valid;
  assign gold_ready = in_run && !ZERO_RUN && accept_en && dut_valid;
  assign xfer       = in_run && !ZERO_RUN && accept_en && dut_valid && gold_valid;
  assign mismatch   = (dut_data != gold_data);

  assign sample_inc     = sample_count + CNT_ONE;
  assign mismatch_inc   = (mismatch_count == CNT_MAX) ? CNT_MAX : mismatch_count + CNT_ONE;
  assign sample_after   = xfer ? sample_inc : sample_count;
  assign mismatch_after = (xfer && mismatch) ? mismatch_inc : mismatch_count;

  assign hit_count  = xfer && (sample_inc == SAMPLE_TARGET);
  assign hit_errors = ABORT_EN && xfer && mismatch && (mismatch_inc == ERROR_LIMIT);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    run_start  = 1'b0;
    finish     = 1'b0;
    wd_expire  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          run_start  = 1'b1;
        end
      end
      RUN: begin
        // A transfer in the expiry cycle wins over the watchdog.
        wd_expire = !xfer && (watchdog == WD_LIMIT);
        if (ZERO_RUN || hit_count || hit_errors || wd_expire) begin
          state_next = DONE;
          finish     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous active-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_count    <= '0;
      mismatch_count  <= '0;
      first_err_index <= '0;
      first_err_valid <= 1'b0;
      watchdog        <= '0;
      timeout         <= 1'b0;
      pass            <= 1'b0;
    end else if (run_start) begin
      sample_count    <= '0;
      mismatch_count  <= '0;
      first_err_index <= '0;
      first_err_valid <= 1'b0;
      watchdog        <= '0;
      timeout         <= 1'b0;
      pass            <= 1'b0;
    end else if (in_run) begin
      if (xfer) begin
        sample_count <= sample_inc;
        watchdog     <= '0;
        if (mismatch) begin
          mismatch_count <= mismatch_inc;
          if (!first_err_valid) begin
            first_err_index <= sample_count;
            first_err_valid <= 1'b1;
          end
        end
      end else begin
        watchdog <= watchdog + CNT_ONE;
      end
      if (finish) begin
        timeout <= wd_expire;
        pass    <= !wd_expire && (mismatch_after == '0) && (sample_after == SAMPLE_TARGET);
      end
    end
  end

endmodule
